regfile_mp: RTL and testbench

Parametrised multi-port register file for the pipeline decode/writeback stages. It generalises the single-write, two-read register file to NUM_RD read ports and two prioritised write ports, with optional write-to-read bypass and an optional hardwired-zero register. It adds a sequential post-reset clear sweep with a ready flag, and a registered debug/SW read port with a one-cycle request/valid handshake.

---
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised write ports,
// post-reset clear sweep with ready flag, and a registered debug read port.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic                     o_ready,
  input  logic                     i_we0,
  input  logic [ADDR_W-1:0]        i_waddr0,
  input  logic [DATA_W-1:0]        i_wdata0,
  input  logic                     i_we1,
  input  logic [ADDR_W-1:0]        i_waddr1,
  input  logic [DATA_W-1:0]        i_wdata1,
  input  logic [NUM_RD-1:0]        i_re,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  input  logic                     i_dbg_req,
  input  logic [ADDR_W-1:0]        i_dbg_addr,
  output logic                     o_dbg_valid,
  output logic [DATA_W-1:0]        o_dbg_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic {StClear, StRun} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_clr_idx;
  logic                r_ready;
  logic                r_dbg_valid;
  logic [DATA_W-1:0]   r_dbg_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_run;
  logic                w_we0;
  logic                w_we1;
  logic [DATA_W-1:0]   w_dbg_word;

  assign w_run = (r_state == StRun) && !i_rst;
  // Address 0 writes are dropped up front so the bypass path never forwards them.
  assign w_we0 = w_run && i_we0 && !(ZERO_REG && (i_waddr0 == '0));
  assign w_we1 = w_run && i_we1 && !(ZERO_REG && (i_waddr1 == '0));
  assign w_dbg_word = (ZERO_REG && (i_dbg_addr == '0)) ? '0 : r_mem[i_dbg_addr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StClear;
      r_clr_idx   <= '0;
      r_ready     <= 1'b0;
      r_dbg_valid <= 1'b0;
      r_dbg_rdata <= '0;
    end else begin
      case (r_state)
        StClear: begin
          r_dbg_valid <= 1'b0;
          r_clr_idx   <= r_clr_idx + 1'b1;
          if (r_clr_idx == LastIdx) begin
            r_state <= StRun;
            r_ready <= 1'b1;
          end
        end
        StRun: begin
          r_dbg_valid <= i_dbg_req;
          if (i_dbg_req) r_dbg_rdata <= w_dbg_word;
        end
      endcase
    end
  end

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == StClear) begin
        r_mem[r_clr_idx] <= '0;
      end else begin
        if (w_we0) r_mem[i_waddr0] <= i_wdata0;
        if (w_we1) r_mem[i_waddr1] <= i_wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = i_raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = '0;
      if (w_run && i_re[k] && !(ZERO_REG && (w_addr == '0))) begin
        if (BYPASS && w_we1 && (i_waddr1 == w_addr)) begin
          w_data = i_wdata1;
        end else if (BYPASS && w_we0 && (i_waddr0 == w_addr)) begin
          w_data = i_wdata0;
        end else begin
          w_data = r_mem[w_addr];
        end
      end
    end

    assign o_rdata[k*DATA_W +: DATA_W] = w_data;
  end

  assign o_ready     = r_ready;
  assign o_dbg_valid = r_dbg_valid;
  assign o_dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default instance plus a BYPASS=0/ZERO_REG=0 instance
// driven by the same stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1, dbg_addr;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic        dbg_req;

  logic        ready, alt_ready;
  logic [63:0] rdata, alt_rdata;
  logic        dbg_valid, alt_dbg_valid;
  logic [31:0] dbg_rdata, alt_dbg_rdata;

  always #5 clk = ~clk;

  regfile_mp dut (
    .i_clk(clk), .i_rst(rst), .o_ready(ready),
    .i_we0(we0), .i_waddr0(waddr0), .i_wdata0(wdata0),
    .i_we1(we1), .i_waddr1(waddr1), .i_wdata1(wdata1),
    .i_re(re), .i_raddr(raddr), .o_rdata(rdata),
    .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr),
    .o_dbg_valid(dbg_valid), .o_dbg_rdata(dbg_rdata)
  );

  regfile_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) dut_alt (
    .i_clk(clk), .i_rst(rst), .o_ready(alt_ready),
    .i_we0(we0), .i_waddr0(waddr0), .i_wdata0(wdata0),
    .i_we1(we1), .i_waddr1(waddr1), .i_wdata1(wdata1),
    .i_re(re), .i_raddr(raddr), .o_rdata(alt_rdata),
    .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr),
    .o_dbg_valid(alt_dbg_valid), .o_dbg_rdata(alt_dbg_rdata)
  );

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    int          cyc;
    logic [31:0] exp;
  } dbg_t;

  chk_t chk_q[$];
  dbg_t dbg_q[$];
  int   cyc_cnt = 0;
  int   n_pass  = 0;
  int   n_total = 0;
  bool_t_dummy_unused_guard g_unused ();

  localparam int SigRd0 = 0, SigRd1 = 1, SigRdy = 2, SigAltRd0 = 3, SigAltRd1 = 4,
                 SigAltRdy = 5, SigDbgV = 6;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc_cnt, act, exp);
  endtask

  function automatic logic [31:0] sel(input int sig);
    case (sig)
      SigRd0:    return rdata[31:0];
      SigRd1:    return rdata[63:32];
      SigRdy:    return {31'b0, ready};
      SigAltRd0: return alt_rdata[31:0];
      SigAltRd1: return alt_rdata[63:32];
      SigAltRdy: return {31'b0, alt_ready};
      default:   return {31'b0, dbg_valid};
    endcase
  endfunction

  task automatic expect_now(input int sig, input logic [31:0] v, input string nm);
    chk_t c;
    c.cyc = cyc_cnt; c.sig = sig; c.exp = v; c.name = nm;
    chk_q.push_back(c);
  endtask

  task automatic dbg_request(input logic [4:0] a, input logic [31:0] v);
    dbg_t d;
    dbg_req = 1'b1; dbg_addr = a;
    d.cyc = cyc_cnt + 1; d.exp = v;
    dbg_q.push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
  endtask

  // Monitor: compares everything due this cycle, and every debug valid pulse.
  initial begin
    chk_t c;
    dbg_t d;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc_cnt) begin
        c = chk_q.pop_front();
        check(c.name, sel(c.sig), c.exp);
      end
      if (dbg_valid) begin
        if (dbg_q.size() == 0) begin
          check("dbg_unexpected_valid", 32'd1, 32'd0);
        end else begin
          d = dbg_q.pop_front();
          check("dbg_valid_cycle", cyc_cnt, d.cyc);
          check("dbg_rdata", dbg_rdata, d.exp);
        end
      end else if (dbg_q.size() > 0 && dbg_q[0].cyc <= cyc_cnt) begin
        d = dbg_q.pop_front();
        check("dbg_missing_valid", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    re = 2'b11; raddr = '0; dbg_req = 1'b0; dbg_addr = '0;

    // Reset: ready low, reads zero
    for (int i = 0; i < 3; i++) begin
      tick();
      set_rd(5'd3, 5'd5);
      expect_now(SigRdy, 32'd0, "rst_ready");
      expect_now(SigRd0, 32'd0, "rst_rdata0");
      expect_now(SigRd1, 32'd0, "rst_rdata1");
    end

    // Clear sweep: 32 cycles of ready=0, writes and debug ignored
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      we0 = (i == 2); waddr0 = 5'd5; wdata0 = 32'hDEAD;
      dbg_req = (i == 4); dbg_addr = 5'd3;
      set_rd(5'd5, 5'd3);
      expect_now(SigRdy, 32'd0, "clr_ready");
      expect_now(SigAltRdy, 32'd0, "clr_alt_ready");
      expect_now(SigRd0, 32'd0, "clr_rdata0");
      if (i == 5 || i == 6) expect_now(SigDbgV, 32'd0, "clr_dbg_valid");
      tick();
    end
    we0 = 1'b0; dbg_req = 1'b0;
    expect_now(SigRdy, 32'd1, "run_ready");
    expect_now(SigAltRdy, 32'd1, "run_alt_ready");
    expect_now(SigRd0, 32'd0, "clr_write_dropped");
    expect_now(SigAltRd0, 32'd0, "clr_write_dropped_alt");

    // Basic write/read with same-cycle bypass
    tick();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h12345678; set_rd(5'd3, 5'd3);
    expect_now(SigRd0, 32'h12345678, "bypass_we0");
    expect_now(SigAltRd0, 32'd0, "nobypass_we0");
    tick();
    we0 = 1'b0;
    expect_now(SigRd0, 32'h12345678, "rd_p0");
    expect_now(SigRd1, 32'h12345678, "rd_p1");
    expect_now(SigAltRd1, 32'h12345678, "alt_rd_p1");
    tick();
    re = 2'b01;
    expect_now(SigRd0, 32'h12345678, "re_p0_on");
    expect_now(SigRd1, 32'd0, "re_p1_off");
    tick();
    re = 2'b11;

    // Write collision: port 1 wins, in the bypass and in the array
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA0000;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555FFFF;
    set_rd(5'd7, 5'd3);
    expect_now(SigRd0, 32'h5555FFFF, "collide_bypass");
    expect_now(SigAltRd0, 32'd0, "collide_nobypass_old");
    tick();
    we0 = 1'b0; we1 = 1'b0;
    expect_now(SigRd0, 32'h5555FFFF, "collide_stored");
    expect_now(SigAltRd0, 32'h5555FFFF, "collide_stored_alt");

    // Zero register
    tick();
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF; set_rd(5'd0, 5'd0);
    expect_now(SigRd0, 32'd0, "zero_same_cycle");
    expect_now(SigAltRd0, 32'd0, "alt_zero_same_cycle_old");
    tick();
    we1 = 1'b0;
    expect_now(SigRd0, 32'd0, "zero_next_cycle");
    expect_now(SigAltRd1, 32'hFFFFFFFF, "alt_r0_written");

    // Debug handshake: back-to-back, no bypass on the first request
    tick();
    dbg_request(5'd3, 32'h12345678);
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h1;
    tick();
    we0 = 1'b0;
    dbg_request(5'd4, 32'h1);
    tick();
    dbg_request(5'd0, 32'd0);
    tick();
    dbg_req = 1'b0;
    tick();
    expect_now(SigDbgV, 32'd0, "dbg_idle");

    // Fill 1..31 with their index, then reset mid-run
    for (int i = 1; i < 32; i++) begin
      we1 = 1'b1; waddr1 = 5'(i); wdata1 = 32'(i);
      tick();
    end
    we1 = 1'b0;
    set_rd(5'd31, 5'd17);
    expect_now(SigRd0, 32'd31, "fill_r31");
    expect_now(SigRd1, 32'd17, "fill_r17");
    tick();
    rst = 1'b1;
    expect_now(SigRdy, 32'd1, "rst_cycle_ready_still_high");
    expect_now(SigRd0, 32'd0, "rst_cycle_rdata0");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expect_now(SigRdy, 32'd0, "reclr_ready");
      tick();
    end
    expect_now(SigRdy, 32'd1, "reclr_ready_up");
    for (int i = 0; i < 16; i++) begin
      set_rd(5'(2 * i), 5'(2 * i + 1));
      expect_now(SigRd0, 32'd0, "reclr_rd0");
      expect_now(SigRd1, 32'd0, "reclr_rd1");
      expect_now(SigAltRd0, 32'd0, "reclr_alt_rd0");
      expect_now(SigAltRd1, 32'd0, "reclr_alt_rd1");
      tick();
    end

    tick();
    tick();
    if (chk_q.size() != 0) check("chk_queue_drained", chk_q.size(), 32'd0);
    if (dbg_q.size() != 0) check("dbg_queue_drained", dbg_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// Empty helper module; no ports, no logic.
module bool_t_dummy_unused_guard;
endmodule
